ss_wbarb: RTL and testbench
===========================

# ss_wbarb

Two-port Wishbone arbiter that shares the single DMA Wishbone master port between the source-side (read) and destination-side (write) scatter-gather engines. Each engine drives a full request bundle (cyc/stb/we/pref/cab/sel/adr). The arbiter grants one engine at a time with round-robin fairness and holds the grant for the whole `cyc` burst. It routes ack/err/rty back to the owner only, and runs a bus watchdog that converts a hung transfer into an `err` to the owner.

## Interface
Parameters:
- `TO_W`, 8: width of the watchdog counter.
- `TIMEOUT`, 8'd255: cycles with `stb` high and no ack/err/rty before a timeout fires.

Ports:
- `wb_clk_i`  in  1  clock.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `ss_done`  in  1  job done from the adma controller; synchronous abort to IDLE, clears the sticky timeout flag.
- `m0_cyc, m0_stb, m0_we, m0_pref, m0_cab`  in  1 each  requester 0 (source SG) bus controls.
- `m0_sel`  in  4  requester 0 byte select.
- `m0_adr`  in  32  requester 0 address.
- `m0_ack, m0_err, m0_rty`  out  1 each  responses to requester 0.
- `m1_*`  same set  requester 1 (destination SG).
- `wbm_cyc, wbm_stb, wbm_we, wbm_pref, wbm_cab`  out  1 each  shared master controls.
- `wbm_sel`  out  4  shared master byte select.
- `wbm_adr`  out  32  shared master address.
- `wbm_ack, wbm_err, wbm_rty`  in  1 each  slave responses.
- `wbm_dat_o, wbm_dat64_o`  in  32 each  read data; not muxed, fanned out to both requesters externally.
- `arb_gnt`  out  2  one-hot current owner; 00 when idle.
- `arb_to`  out  1  sticky timeout flag.
- `arb_to_id`  out  1  requester that timed out.

## Operation
- States: IDLE, GNT0, GNT1, TOUT. Registered `state` (2 bits), `last` (last served, 1 bit), `tcnt` (TO_W bits), `to_id`.
- IDLE:
  - Only `m0_cyc` high → GNT0. Only `m1_cyc` high → GNT1.
  - Both high → grant the requester that is not `last`.
  - Entering GNTx sets `last`=x and clears `tcnt`.
- GNTx:
  - `wbm_*` outputs equal `mx_*` combinationally.
  - `mx_ack/err/rty` equal `wbm_ack/err/rty`. The other requester's responses are 0.
  - Exit when `mx_cyc`=0: if the other requester's `cyc`=1, go straight to GNT(other) with no idle cycle; otherwise go to IDLE.
- IDLE and TOUT drive all `wbm_*` outputs to 0 and all `m*_ack/err/rty` to 0, except the single TOUT error pulse below.
- Watchdog, in GNTx:
  - `tcnt` increments each cycle that `mx_stb`=1 and `wbm_ack|wbm_err|wbm_rty`=0.
  - `tcnt` clears on any response or when `mx_stb`=0.
  - When `tcnt`==TIMEOUT, go to TOUT. This sets `arb_to`=1, `to_id`=x, and drives `mx_err`=1 for exactly one cycle, the first TOUT cycle.
- TOUT: stay until `m{to_id}_cyc`=0, then follow the GNTx exit rule.
- `ss_done`=1 forces `state`=IDLE, `tcnt`=0 and `arb_to`=0 at the next edge. `last` is preserved.
- Responses arriving in IDLE or TOUT are dropped.

## Timing
- Reset values: state IDLE, `last`=1 (so m0 wins the first tie), `tcnt`=0, `arb_to`=0, `arb_to_id`=0.
- Output values at reset: all `wbm_*`=0, all `m*_ack/err/rty`=0, `arb_gnt`=00.
- Grant latency: `mx_cyc` rising at edge N → state GNTx after edge N+1; `wbm_cyc` follows combinationally in that cycle.
- Zero-latency passthrough of requests and responses while granted.
- Handoff: owner drops `cyc` in cycle N, other requester waiting → new owner's signals on `wbm_*` from cycle N+1.
- Reset asserted mid-burst: state IDLE immediately (asynchronous), and `wbm_cyc`=0 in the same cycle.
- Simultaneous `ss_done` and a timeout: `ss_done` wins; no `err` pulse is issued.
- `TIMEOUT`=0 is illegal. The counter saturates at TIMEOUT and never wraps.

## Test plan
- Single requester: m0 raises `cyc/stb` with adr=0x1000 → `arb_gnt`=01 one cycle later, `wbm_adr`=0x1000. Four `wbm_ack` pulses appear on `m0_ack` only.
- Tie after reset: m0 and m1 raise `cyc` in the same cycle → GNT0 first. When m0 drops `cyc`, GNT1 starts the next cycle with no IDLE cycle.
- Fairness: m1 served last, both then request → GNT0. Repeat → GNT1. Grants alternate over 8 rounds.
- Watchdog: TIMEOUT=4, m1 holds `stb` with no response → `m1_err` pulses in cycle 6 after grant, `arb_to`=1, `arb_to_id`=1, `wbm_cyc`=0. m1 drops `cyc` → IDLE.
- `ss_done` during a GNT1 burst: next cycle `arb_gnt`=00, `wbm_cyc`=0, `arb_to` cleared. `wbm_ack` in that IDLE cycle is not seen on `m1_ack`.
- Async reset asserted mid-burst: `wbm_cyc`=0 within the same cycle. After release, m0 wins the first tie.

Source files
------------

// File: rtl/ss_wbarb.sv
// Round-robin arbiter sharing one Wishbone master between the source and destination SG engines.
// Grants hold for a whole cyc burst; a watchdog turns a stalled strobe into a one-cycle err to the owner.
module ss_wbarb #(
    parameter int unsigned     TO_W    = 8,
    parameter logic [TO_W-1:0] TIMEOUT = 8'd255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        ss_done,

    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic        m0_pref,
    input  logic        m0_cab,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_adr,
    output logic        m0_ack,
    output logic        m0_err,
    output logic        m0_rty,

    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic        m1_pref,
    input  logic        m1_cab,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_adr,
    output logic        m1_ack,
    output logic        m1_err,
    output logic        m1_rty,

    output logic        wbm_cyc,
    output logic        wbm_stb,
    output logic        wbm_we,
    output logic        wbm_pref,
    output logic        wbm_cab,
    output logic [3:0]  wbm_sel,
    output logic [31:0] wbm_adr,
    input  logic        wbm_ack,
    input  logic        wbm_err,
    input  logic        wbm_rty,
    input  logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat64_o,

    output logic [1:0]  arb_gnt,
    output logic        arb_to,
    output logic        arb_to_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        TOUT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic [TO_W-1:0] tcnt_q, tcnt_d;
    logic            to_q, to_d;
    logic            to_id_q, to_id_d;
    logic            tpulse_q, tpulse_d;
    logic [1:0]      gnt_q, gnt_d;

    logic own0, own1, resp;
    logic cur_id, cur_cyc, cur_stb, oth_cyc;
    logic go_grant, go_id;

    // Read data is fanned out to both engines outside this block.
    logic unused_dat;
    assign unused_dat = ^{wbm_dat_o, wbm_dat64_o};

    assign own0 = (state_q == GNT0);
    assign own1 = (state_q == GNT1);
    assign resp = wbm_ack | wbm_err | wbm_rty;

    always_comb begin
        // In TOUT the "owner" is the requester that timed out.
        cur_id   = (state_q == GNT1) || ((state_q == TOUT) && to_id_q);
        cur_cyc  = cur_id ? m1_cyc : m0_cyc;
        cur_stb  = cur_id ? m1_stb : m0_stb;
        oth_cyc  = cur_id ? m0_cyc : m1_cyc;
        state_d  = state_q;
        last_d   = last_q;
        tcnt_d   = tcnt_q;
        to_d     = to_q;
        to_id_d  = to_id_q;
        tpulse_d = 1'b0;
        go_grant = 1'b0;
        go_id    = 1'b0;
        gnt_d    = 2'b00;

        case (state_q)
            IDLE: begin
                if (m0_cyc && (!m1_cyc || last_q)) begin
                    go_grant = 1'b1;
                    go_id    = 1'b0;
                end else if (m1_cyc) begin
                    go_grant = 1'b1;
                    go_id    = 1'b1;
                end
            end
            GNT0, GNT1, TOUT: begin
                if (!cur_cyc) begin
                    if (oth_cyc) begin
                        go_grant = 1'b1;
                        go_id    = !cur_id;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (state_q != TOUT) begin
                    if (tcnt_q == TIMEOUT) begin
                        state_d  = TOUT;
                        to_d     = 1'b1;
                        to_id_d  = cur_id;
                        tpulse_d = 1'b1;
                        tcnt_d   = '0;
                    end else if (cur_stb && !resp) begin
                        tcnt_d = tcnt_q + TO_W'(1);
                    end else begin
                        tcnt_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (go_grant) begin
            state_d = go_id ? GNT1 : GNT0;
            last_d  = go_id;
            tcnt_d  = '0;
        end

        // Job-done abort overrides everything, including a timeout firing this cycle.
        if (ss_done) begin
            state_d  = IDLE;
            tcnt_d   = '0;
            to_d     = 1'b0;
            tpulse_d = 1'b0;
        end

        case (state_d)
            GNT0:    gnt_d = 2'b01;
            GNT1:    gnt_d = 2'b10;
            default: gnt_d = 2'b00;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            tcnt_q   <= '0;
            to_q     <= 1'b0;
            to_id_q  <= 1'b0;
            tpulse_q <= 1'b0;
            gnt_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            tcnt_q   <= tcnt_d;
            to_q     <= to_d;
            to_id_q  <= to_id_d;
            tpulse_q <= tpulse_d;
            gnt_q    <= gnt_d;
        end
    end

    always_comb begin
        wbm_cyc  = 1'b0;
        wbm_stb  = 1'b0;
        wbm_we   = 1'b0;
        wbm_pref = 1'b0;
        wbm_cab  = 1'b0;
        wbm_sel  = 4'h0;
        wbm_adr  = 32'h0;
        if (own0) begin
            wbm_cyc  = m0_cyc;
            wbm_stb  = m0_stb;
            wbm_we   = m0_we;
            wbm_pref = m0_pref;
            wbm_cab  = m0_cab;
            wbm_sel  = m0_sel;
            wbm_adr  = m0_adr;
        end else if (own1) begin
            wbm_cyc  = m1_cyc;
            wbm_stb  = m1_stb;
            wbm_we   = m1_we;
            wbm_pref = m1_pref;
            wbm_cab  = m1_cab;
            wbm_sel  = m1_sel;
            wbm_adr  = m1_adr;
        end
    end

    assign m0_ack = own0 & wbm_ack;
    assign m0_rty = own0 & wbm_rty;
    assign m0_err = (own0 & wbm_err) | (tpulse_q & (state_q == TOUT) & !to_id_q);
    assign m1_ack = own1 & wbm_ack;
    assign m1_rty = own1 & wbm_rty;
    assign m1_err = (own1 & wbm_err) | (tpulse_q & (state_q == TOUT) & to_id_q);

    assign arb_gnt   = gnt_q;
    assign arb_to    = to_q;
    assign arb_to_id = to_id_q;

endmodule

// File: tb/tb_ss_wbarb.sv
// Scoreboard bench for ss_wbarb: directed stimulus queues expected snapshots, a monitor compares them.
module tb_ss_wbarb;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        ss_done  = 1'b0;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0, m0_pref = 0, m0_cab = 0;
    logic [3:0]  m0_sel = 4'hf;
    logic [31:0] m0_adr = 32'h0;
    logic        m0_ack, m0_err, m0_rty;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0, m1_pref = 0, m1_cab = 0;
    logic [3:0]  m1_sel = 4'hf;
    logic [31:0] m1_adr = 32'h0;
    logic        m1_ack, m1_err, m1_rty;
    logic        wbm_cyc, wbm_stb, wbm_we, wbm_pref, wbm_cab;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_adr;
    logic        wbm_ack = 0, wbm_err = 0, wbm_rty = 0;
    logic [31:0] wbm_dat_o = 32'h0, wbm_dat64_o = 32'h0;
    logic [1:0]  arb_gnt;
    logic        arb_to, arb_to_id;

    always #5 wb_clk_i = ~wb_clk_i;

    ss_wbarb #(.TO_W(8), .TIMEOUT(8'd4)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .ss_done(ss_done),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_pref(m0_pref), .m0_cab(m0_cab),
        .m0_sel(m0_sel), .m0_adr(m0_adr), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_pref(m1_pref), .m1_cab(m1_cab),
        .m1_sel(m1_sel), .m1_adr(m1_adr), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty),
        .wbm_cyc(wbm_cyc), .wbm_stb(wbm_stb), .wbm_we(wbm_we), .wbm_pref(wbm_pref), .wbm_cab(wbm_cab),
        .wbm_sel(wbm_sel), .wbm_adr(wbm_adr), .wbm_ack(wbm_ack), .wbm_err(wbm_err), .wbm_rty(wbm_rty),
        .wbm_dat_o(wbm_dat_o), .wbm_dat64_o(wbm_dat64_o),
        .arb_gnt(arb_gnt), .arb_to(arb_to), .arb_to_id(arb_to_id)
    );

    // Snapshot layout: {gnt[44:43], to, to_id, cyc, stb, we, adr[37:6], m0 ack/err/rty, m1 ack/err/rty}
    localparam logic [44:0] M_GNT  = 45'h3 << 43;
    localparam logic [44:0] M_TO   = 45'h1 << 42;
    localparam logic [44:0] M_TOID = 45'h1 << 41;
    localparam logic [44:0] M_CYC  = 45'h1 << 40;
    localparam logic [44:0] M_STB  = 45'h1 << 39;
    localparam logic [44:0] M_WE   = 45'h1 << 38;
    localparam logic [44:0] M_ADR  = 45'hFFFF_FFFF << 6;
    localparam logic [44:0] M_RSP  = 45'h3F;
    localparam logic [44:0] M_ALL  = {45{1'b1}};
    localparam logic [5:0]  R_M0ACK = 6'b100000;
    localparam logic [5:0]  R_M1ERR = 6'b000010;

    typedef struct {
        int          cyc;
        string       nm;
        logic [44:0] m;
        logic [44:0] v;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc_n = 0;
    logic exp_w;

    always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

    function automatic logic [44:0] snap();
        return {arb_gnt, arb_to, arb_to_id, wbm_cyc, wbm_stb, wbm_we, wbm_adr,
                m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty};
    endfunction

    task automatic push(input string nm, input logic [44:0] m, input logic [1:0] g,
                        input logic to, input logic tid, input logic c, input logic s,
                        input logic w, input logic [31:0] a, input logic [5:0] r);
        exp_t e;
        e.cyc = cyc_n;
        e.nm  = nm;
        e.m   = m;
        e.v   = {g, to, tid, c, s, w, a, r} & m;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Monitor: compares queued expectations for the current cycle, also right after an async reset.
    initial begin : monitor
        exp_t        e;
        logic [44:0] got;
        forever begin
            @(negedge wb_clk_i or posedge wb_rst_i);
            #1;
            while (sbq.size() > 0 && sbq[0].cyc <= cyc_n) begin
                e   = sbq.pop_front();
                got = snap() & e.m;
                n_chk++;
                if (got !== e.v) begin
                    n_fail++;
                    $display("FAIL %s cycle=%0d got=%h expected=%h mask=%h", e.nm, cyc_n, got, e.v, e.m);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        tick();
        push("reset_outputs", M_ALL, 2'b00, 0, 0, 0, 0, 0, 32'h0, 6'h0);
        tick();
        wb_rst_i = 1'b0;

        // Tie right after reset: m0 first, then seamless handoff to m1.
        m0_cyc = 1; m0_adr = 32'h2000;
        m1_cyc = 1; m1_adr = 32'h3000; m1_we = 1;
        push("tie_still_idle", M_GNT | M_CYC, 2'b00, 0, 0, 0, 0, 0, 32'h0, 6'h0);
        tick();
        n_chk++;
        if (arb_gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL direct_tie_gnt0 got=%b expected=01", arb_gnt);
        end
        push("tie_gnt0", M_GNT | M_CYC | M_WE | M_ADR, 2'b01, 0, 0, 1, 0, 0, 32'h2000, 6'h0);
        tick();
        wbm_ack = 1;
        push("tie_ack_m0_only", M_GNT | M_RSP, 2'b01, 0, 0, 0, 0, 0, 32'h0, R_M0ACK);
        tick();
        wbm_ack = 0; m0_cyc = 0;
        push("handoff_drop", M_GNT | M_CYC, 2'b01, 0, 0, 0, 0, 0, 32'h0, 6'h0);
        tick();
        n_chk++;
        if (arb_gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL direct_handoff_gnt1 got=%b expected=10", arb_gnt);
        end
        push("handoff_gnt1", M_GNT | M_CYC | M_WE | M_ADR, 2'b10, 0, 0, 1, 0, 1, 32'h3000, 6'h0);
        tick();
        m1_cyc = 0; m1_we = 0;
        push("gnt1_drop", M_GNT | M_CYC, 2'b10, 0, 0, 0, 0, 0, 32'h0, 6'h0);
        tick();
        push("back_idle", M_GNT | M_CYC, 2'b00, 0, 0, 0, 0, 0, 32'h0, 6'h0);

        // Single requester with four acks.
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h1000;
        push("single_req_idle", M_GNT | M_CYC, 2'b00, 0, 0, 0, 0, 0, 32'h0, 6'h0);
        tick();
        wbm_ack = 1;
        for (int i = 0; i < 4; i++) begin
            push("single_ack", M_GNT | M_CYC | M_STB | M_ADR | M_RSP, 2'b01, 0, 0, 1, 1, 0, 32'h1000, R_M0ACK);
            tick();
        end
        wbm_ack = 0; m0_cyc = 0; m0_stb = 0;
        push("single_end", M_GNT | M_CYC | M_RSP, 2'b01, 0, 0, 0, 0, 0, 32'h0, 6'h0);
        tick();
        push("single_idle", M_GNT, 2'b00, 0, 0, 0, 0, 0, 32'h0, 6'h0);

        // Fairness: m0 served last, so ties alternate starting with m1.
        exp_w = 1'b1;
        for (int r = 0; r < 8; r++) begin
            m0_cyc = 1; m1_cyc = 1;
            tick();
            push("rr_winner", M_GNT, exp_w ? 2'b10 : 2'b01, 0, 0, 0, 0, 0, 32'h0, 6'h0);
            m0_cyc = 0; m1_cyc = 0;
            tick();
            push("rr_idle", M_GNT, 2'b00, 0, 0, 0, 0, 0, 32'h0, 6'h0);
            exp_w = !exp_w;
        end

        // Watchdog on m1 with TIMEOUT=4: err in the sixth granted-or-after cycle.
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h4000;
        tick();
        push("wd_gnt", M_GNT | M_STB | M_ADR | M_TO, 2'b10, 0, 0, 0, 1, 0, 32'h4000, 6'h0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            push("wd_wait", M_GNT | M_RSP | M_TO, 2'b10, 0, 0, 0, 0, 0, 32'h0, 6'h0);
        end
        tick();
        n_chk++;
        if (arb_to !== 1'b1 || arb_to_id !== 1'b1) begin
            n_fail++;
            $display("FAIL direct_wd_flag got to=%b id=%b expected to=1 id=1", arb_to, arb_to_id);
        end
        push("wd_err", M_GNT | M_TO | M_TOID | M_CYC | M_RSP, 2'b00, 1, 1, 0, 0, 0, 32'h0, R_M1ERR);
        tick();
        wbm_ack = 1;
        push("wd_pulse_once", M_GNT | M_TO | M_CYC | M_RSP, 2'b00, 1, 0, 0, 0, 0, 32'h0, 6'h0);
        tick();
        wbm_ack = 0; m1_cyc = 0; m1_stb = 0;
        push("wd_hold", M_GNT | M_TO | M_TOID, 2'b00, 1, 1, 0, 0, 0, 32'h0, 6'h0);
        tick();
        push("wd_sticky", M_GNT | M_TO | M_TOID, 2'b00, 1, 1, 0, 0, 0, 32'h0, 6'h0);

        // ss_done during a GNT1 burst.
        m1_cyc = 1;
        tick();
        push("done_pre", M_GNT | M_CYC | M_TO, 2'b10, 1, 0, 1, 0, 0, 32'h0, 6'h0);
        ss_done = 1;
        tick();
        ss_done = 0; wbm_ack = 1;
        push("done_abort", M_GNT | M_CYC | M_TO | M_RSP, 2'b00, 0, 0, 0, 0, 0, 32'h0, 6'h0);
        tick();
        wbm_ack = 0;
        push("done_regrant", M_GNT, 2'b10, 0, 0, 0, 0, 0, 32'h0, 6'h0);
        m1_cyc = 0;
        tick();
        push("done_idle", M_GNT, 2'b00, 0, 0, 0, 0, 0, 32'h0, 6'h0);

        // ss_done in the same cycle the watchdog would fire: no err pulse.
        m1_cyc = 1; m1_stb = 1;
        tick();
        push("wdd_gnt", M_GNT, 2'b10, 0, 0, 0, 0, 0, 32'h0, 6'h0);
        for (int k = 1; k <= 3; k++) tick();
        tick();
        ss_done = 1;
        push("wdd_pre", M_GNT | M_RSP, 2'b10, 0, 0, 0, 0, 0, 32'h0, 6'h0);
        tick();
        ss_done = 0;
        push("wdd_no_err", M_GNT | M_TO | M_RSP, 2'b00, 0, 0, 0, 0, 0, 32'h0, 6'h0);
        m1_cyc = 0; m1_stb = 0;
        tick();
        push("wdd_idle", M_GNT | M_TO | M_RSP, 2'b00, 0, 0, 0, 0, 0, 32'h0, 6'h0);

        // Async reset mid-burst on m0, then a tie that m0 must win.
        m0_cyc = 1; m0_adr = 32'h5000;
        tick();
        push("rst_pre", M_GNT | M_CYC, 2'b01, 0, 0, 1, 0, 0, 32'h0, 6'h0);
        @(negedge wb_clk_i);
        #2;
        wb_rst_i = 1'b1;
        push("rst_async", M_GNT | M_CYC, 2'b00, 0, 0, 0, 0, 0, 32'h0, 6'h0);
        tick();
        push("rst_hold", M_GNT | M_CYC | M_TO | M_TOID, 2'b00, 0, 0, 0, 0, 0, 32'h0, 6'h0);
        m1_cyc = 1; m1_adr = 32'h6000;
        wb_rst_i = 1'b0;
        push("rst_rel_idle", M_GNT, 2'b00, 0, 0, 0, 0, 0, 32'h0, 6'h0);
        tick();
        n_chk++;
        if (arb_gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL direct_rst_tie_m0 got=%b expected=01", arb_gnt);
        end
        push("rst_tie_m0", M_GNT | M_ADR, 2'b01, 0, 0, 0, 0, 0, 32'h5000, 6'h0);
        m0_cyc = 0; m1_cyc = 0;
        tick();
        tick();
        push("final_idle", M_GNT | M_CYC, 2'b00, 0, 0, 0, 0, 0, 32'h0, 6'h0);
        tick();
        tick();

        while (sbq.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s not evaluated (queued for cycle %0d)", sbq[0].nm, sbq[0].cyc);
            void'(sbq.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
